// File: rtl/keypad_hex_scan.sv
// 4x4 matrix keypad scanner: column scan, row sync, per-frame press classification,
// debounce FSM and a one-entry valid/ready buffer for the accepted hex digit.
module keypad_hex_scan #(
  parameter int N         = 17,
  parameter int DB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int CW = $clog2(DB_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

  logic [N+1:0] scan_q;
  logic [1:0]   col_idx;
  logic         slot_end;
  logic [3:0]   row_meta_q, row_sync_q;
  logic [3:0]   pressed_rows;
  logic [2:0]   col_hits;
  logic [3:0]   col_code;
  logic [3:0]   hit_sum;
  logic [1:0]   acc_cnt_q, acc_cnt_d;
  logic [3:0]   acc_code_q, acc_code_d;
  logic [1:0]   verdict_cnt_q;
  logic [3:0]   verdict_code_q;
  logic         frame_done_q;
  logic         verdict_none, verdict_single;
  logic         accept;
  state_e       state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]   cand_q;
  logic [3:0]   key_code_q;
  logic         key_valid_q, key_held_q, overrun_q;

  function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign col_idx      = scan_q[N+1:N];
  assign slot_end     = &scan_q[N-1:0];
  assign col_n        = ~(4'b0001 << col_idx);
  assign pressed_rows = ~row_sync_q;

  // Per-column contribution: hit count and the code of the lowest pressed row.
  always_comb begin
    col_hits = {2'b00, pressed_rows[0]} + {2'b00, pressed_rows[1]}
             + {2'b00, pressed_rows[2]} + {2'b00, pressed_rows[3]};
    col_code = keyMap(2'd3, col_idx);
    if (pressed_rows[0])      col_code = keyMap(2'd0, col_idx);
    else if (pressed_rows[1]) col_code = keyMap(2'd1, col_idx);
    else if (pressed_rows[2]) col_code = keyMap(2'd2, col_idx);
    hit_sum    = {2'b00, acc_cnt_q} + {1'b0, col_hits};
    acc_cnt_d  = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
    acc_code_d = (col_hits != 3'd0) ? col_code : acc_code_q;
  end

  // Scan counter, row synchronizer and frame accumulation into a registered verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q         <= '0;
      row_meta_q     <= 4'hF;
      row_sync_q     <= 4'hF;
      acc_cnt_q      <= '0;
      acc_code_q     <= '0;
      verdict_cnt_q  <= '0;
      verdict_code_q <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      scan_q       <= scan_q + 1'b1;
      row_meta_q   <= row_n;
      row_sync_q   <= row_meta_q;
      frame_done_q <= 1'b0;
      if (slot_end) begin
        if (col_idx == 2'd3) begin
          verdict_cnt_q  <= acc_cnt_d;
          verdict_code_q <= acc_code_d;
          frame_done_q   <= 1'b1;
          acc_cnt_q      <= '0;
          acc_code_q     <= '0;
        end else begin
          acc_cnt_q  <= acc_cnt_d;
          acc_code_q <= acc_code_d;
        end
      end
    end
  end

  assign verdict_none   = (verdict_cnt_q == 2'd0);
  assign verdict_single = (verdict_cnt_q == 2'd1);

  assign accept = frame_done_q && verdict_single &&
                  (((state_q == IDLE) && (DB_FRAMES == 1)) ||
                   ((state_q == DEBOUNCE) && (verdict_code_q == cand_q) &&
                    (cnt_q == CW'(DB_FRAMES - 1))));

  // Debounce FSM steps once per frame; the output buffer shares the same register block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_done_q) begin
        case (state_q)
          IDLE: begin
            if (verdict_single) begin
              cand_q <= verdict_code_q;
              if (DB_FRAMES == 1) begin
                state_q    <= PRESSED;
                key_held_q <= 1'b1;
              end else begin
                state_q <= DEBOUNCE;
                cnt_q   <= CW'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (verdict_single) begin
              if (verdict_code_q == cand_q) begin
                if (cnt_q == CW'(DB_FRAMES - 1)) begin
                  state_q    <= PRESSED;
                  key_held_q <= 1'b1;
                  cnt_q      <= CW'(DB_FRAMES);
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end else begin
                cand_q <= verdict_code_q;
                cnt_q  <= CW'(1);
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          PRESSED: begin
            if (verdict_none) begin
              if (DB_FRAMES == 1) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                state_q <= RELEASE;
                cnt_q   <= CW'(1);
              end
            end
          end
          default: begin
            if (verdict_none) begin
              if (cnt_q == CW'(DB_FRAMES - 1)) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q <= PRESSED;
            end
          end
        endcase
      end

      // A set of overrun in the same cycle overrides the clear.
      if (clr_overrun) overrun_q <= 1'b0;
      if (accept) begin
        if (key_valid_q && !key_ready) begin
          overrun_q <= 1'b1;
        end else begin
          key_code_q  <= verdict_code_q;
          key_valid_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule
